// File: rtl/oled_spi_arbiter_pkg.sv
// Shared encodings for the OLED SPI arbiter: FSM states, owner ids and D/C pin levels.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package oled_spi_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    // Owner encoding, used for last_owner and the round-robin tie break.
    localparam logic OWN_CMD = 1'b0;
    localparam logic OWN_PIX = 1'b1;

    // OLED D/C pin levels: low selects command, high selects display data.
    localparam logic DC_CMD  = 1'b0;
    localparam logic DC_DATA = 1'b1;

endpackage

// File: rtl/oled_spi_rr_sel.sv
// Two-way winner select: lock forces cmd, a single requester wins alone, a tie goes to the non-last owner.
// Latency: purely combinational.
// Backpressure: none; the caller gates the selects into ready outputs.
//
// Ports:
//   i_cmd_valid, i_pix_valid : requests from the command and pixel sides
//   i_lock                   : command side holds the resource; pixel side never selected
//   i_last_owner             : owner of the previous accepted byte (OWN_CMD / OWN_PIX)
//   o_sel_cmd, o_sel_pix     : one-hot (or zero) winner
module oled_spi_rr_sel
    import oled_spi_pkg::*;
(
    input  logic i_cmd_valid,
    input  logic i_pix_valid,
    input  logic i_lock,
    input  logic i_last_owner,
    output logic o_sel_cmd,
    output logic o_sel_pix
);

    always_comb begin
        o_sel_cmd = 1'b0;
        o_sel_pix = 1'b0;
        if (i_lock) begin
            o_sel_cmd = i_cmd_valid;
        end else if (i_cmd_valid && i_pix_valid) begin
            o_sel_cmd = (i_last_owner == OWN_PIX);
            o_sel_pix = (i_last_owner == OWN_CMD);
        end else begin
            o_sel_cmd = i_cmd_valid;
            o_sel_pix = i_pix_valid;
        end
    end

endmodule

// File: rtl/oled_spi_arbiter.sv
// Shares one spi_master between a command sequencer and a pixel source, driving the OLED D/C pin per byte.
// Latency: accept in cycle N -> spi_start_o in N+1 when spi_busy_i=0; at least one idle cycle between transfers.
// Backpressure: readies are combinational, high only in IDLE toward the winner; START waits while spi_busy_i=1.
//
// Ports:
//   clk_i, rstn_i                         : clock, async active-low reset
//   cmd_valid_i/cmd_data_i/cmd_dc_i/cmd_lock_i/cmd_ready_o : command requester handshake
//   pix_valid_i/pix_data_i/pix_ready_o    : pixel requester handshake (D/C forced to data)
//   spi_start_o/spi_data_o/spi_busy_i/spi_done_i : spi_master interface
//   dc_o, grant_o ([0]=cmd,[1]=pix), busy_o, timeout_o : status
// Optional: define OLED_SPI_ARB_TIMEOUT_EN for a TIMEOUT_CYC watchdog in START/WAIT_DONE
// that forces IDLE and sets the sticky timeout_o; otherwise timeout_o is tied low.
module oled_spi_arbiter
    import oled_spi_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  cmd_valid_i,
    input  logic [DATA_WIDTH-1:0] cmd_data_i,
    input  logic                  cmd_dc_i,
    input  logic                  cmd_lock_i,
    output logic                  cmd_ready_o,
    input  logic                  pix_valid_i,
    input  logic [DATA_WIDTH-1:0] pix_data_i,
    output logic                  pix_ready_o,
    output logic                  spi_start_o,
    output logic [DATA_WIDTH-1:0] spi_data_o,
    input  logic                  spi_busy_i,
    input  logic                  spi_done_i,
    output logic                  dc_o,
    output logic [1:0]            grant_o,
    output logic                  busy_o,
    output logic                  timeout_o
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_last_owner;
    logic                  r_lock;
    logic                  r_dc;
    logic [1:0]            r_grant;
    logic [DATA_WIDTH-1:0] r_data;

    logic w_sel_cmd;
    logic w_sel_pix;
    logic w_acc_cmd;
    logic w_acc_pix;
    logic w_to_hit;

    oled_spi_rr_sel u_rr_sel (
        .i_cmd_valid  (cmd_valid_i),
        .i_pix_valid  (pix_valid_i),
        .i_lock       (r_lock),
        .i_last_owner (r_last_owner),
        .o_sel_cmd    (w_sel_cmd),
        .o_sel_pix    (w_sel_pix)
    );

    assign cmd_ready_o = (r_state == IDLE) && w_sel_cmd;
    assign pix_ready_o = (r_state == IDLE) && w_sel_pix;
    assign w_acc_cmd   = cmd_valid_i && cmd_ready_o;
    assign w_acc_pix   = pix_valid_i && pix_ready_o;

`ifdef OLED_SPI_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] r_to_cnt;
    logic             r_timeout;

    // The counter value equals the number of full cycles already spent in the
    // current state, so the hit fires in the TIMEOUT_CYC-th cycle.
    assign w_to_hit = (r_state != IDLE) && (r_to_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            if ((r_state == IDLE) || (w_state_nxt != r_state)) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            if (w_to_hit) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign timeout_o = r_timeout;
`else
    assign w_to_hit  = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        spi_start_o = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_acc_cmd || w_acc_pix) begin
                    w_state_nxt = START;
                end
            end
            START: begin
                if (!spi_busy_i) begin
                    spi_start_o = 1'b1;
                    w_state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (spi_done_i) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        // A watchdog abort must not launch a transfer on its way out.
        if (w_to_hit) begin
            w_state_nxt = IDLE;
            spi_start_o = 1'b0;
        end
    end

    // Datapath only loads on accept, so data and D/C stay stable for the whole transfer.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_data       <= '0;
            r_dc         <= 1'b0;
            r_grant      <= 2'b00;
            r_last_owner <= OWN_PIX;
            r_lock       <= 1'b0;
        end else begin
            if (w_acc_cmd) begin
                r_data       <= cmd_data_i;
                r_dc         <= cmd_dc_i;
                r_grant      <= 2'b01;
                r_last_owner <= OWN_CMD;
                r_lock       <= cmd_lock_i;
            end else if (w_acc_pix) begin
                r_data       <= pix_data_i;
                r_dc         <= DC_DATA;
                r_grant      <= 2'b10;
                r_last_owner <= OWN_PIX;
                r_lock       <= 1'b0;
            end else if ((r_state == IDLE) && !cmd_valid_i && !cmd_lock_i) begin
                // Command side went quiet and dropped its lock request.
                r_lock <= 1'b0;
            end

            if ((r_state == WAIT_DONE) && spi_done_i) begin
                r_grant <= 2'b00;
            end
            if (w_to_hit) begin
                r_grant <= 2'b00;
                r_lock  <= 1'b0;
            end
        end
    end

    assign spi_data_o = r_data;
    assign dc_o       = r_dc;
    assign grant_o    = r_grant;
    assign busy_o     = (r_state != IDLE);

endmodule

// File: tb/tb_oled_spi_arbiter.sv
// Self-checking bench for oled_spi_arbiter: directed scenarios plus a randomized run against a transaction model.
// Latency: n/a.
// Backpressure: the bench plays both requesters (hold valid until ready) and the spi_master.
module tb_oled_spi_arbiter;

    logic       clk_i = 1'b0;
    logic       rstn_i;
    logic       cmd_valid_i, cmd_dc_i, cmd_lock_i, pix_valid_i;
    logic [7:0] cmd_data_i, pix_data_i;
    logic       cmd_ready_o, pix_ready_o, spi_start_o;
    logic [7:0] spi_data_o;
    logic       spi_busy_i, spi_done_i, dc_o, busy_o, timeout_o;
    logic [1:0] grant_o;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    oled_spi_arbiter #(.DATA_WIDTH(8), .TIMEOUT_CYC(16)) dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_data_i  (cmd_data_i),
        .cmd_dc_i    (cmd_dc_i),
        .cmd_lock_i  (cmd_lock_i),
        .cmd_ready_o (cmd_ready_o),
        .pix_valid_i (pix_valid_i),
        .pix_data_i  (pix_data_i),
        .pix_ready_o (pix_ready_o),
        .spi_start_o (spi_start_o),
        .spi_data_o  (spi_data_o),
        .spi_busy_i  (spi_busy_i),
        .spi_done_i  (spi_done_i),
        .dc_o        (dc_o),
        .grant_o     (grant_o),
        .busy_o      (busy_o),
        .timeout_o   (timeout_o)
    );

    // Inputs change 1 time unit after the rising edge; outputs are sampled 4 later (falling edge).
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic apply_reset();
        rstn_i = 1'b0;
        cmd_valid_i = 0; cmd_data_i = 0; cmd_dc_i = 0; cmd_lock_i = 0;
        pix_valid_i = 0; pix_data_i = 0; spi_busy_i = 0; spi_done_i = 0;
        repeat (2) tick();
        rstn_i = 1'b1;
    endtask

    // Waits (bounded) for the next spi_start_o, records what was launched, then returns done.
    task automatic run_xfer(input bit no_pix, output logic [1:0] g, output logic [7:0] d,
                            output logic dc);
        bit ok;
        ok = 0; g = 2'b00; d = 8'h00; dc = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            spi_done_i = 0;
            #4;
            if (no_pix) begin
                checks++;
                if (pix_ready_o !== 1'b0) begin
                    errors++;
                    $display("FAIL lock_pix_ready got=%b want=0", pix_ready_o);
                end
            end
            if (spi_start_o === 1'b1) begin
                g = grant_o; d = spi_data_o; dc = dc_o; ok = 1;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL xfer_start got=no spi_start_o want=start within 20 cycles");
        end
        tick(); spi_done_i = 1;
        tick(); spi_done_i = 0;
    endtask

    task automatic test_reset();
        rstn_i = 1'b0;
        cmd_valid_i = 0; cmd_data_i = 0; cmd_dc_i = 0; cmd_lock_i = 0;
        pix_valid_i = 0; pix_data_i = 0; spi_busy_i = 0; spi_done_i = 0;
        tick(); #4;
        checks++;
        if ({spi_start_o, spi_data_o, dc_o, grant_o, busy_o, timeout_o, cmd_ready_o, pix_ready_o} !== 15'h0) begin
            errors++;
            $display("FAIL reset_outputs got=start%b data%h dc%b grant%b busy%b to%b rdy%b%b want=all 0",
                     spi_start_o, spi_data_o, dc_o, grant_o, busy_o, timeout_o, cmd_ready_o, pix_ready_o);
        end
        tick();
        rstn_i = 1'b1;
    endtask

    task automatic test_single_cmd();
        apply_reset();
        cmd_valid_i = 1; cmd_data_i = 8'hAF; cmd_dc_i = 0;
        #4; checks++;
        if (cmd_ready_o !== 1'b1) begin errors++; $display("FAIL single_ready got=%b want=1", cmd_ready_o); end
        tick(); cmd_valid_i = 0;
        #4; checks++;
        if ({spi_start_o, spi_data_o, dc_o, grant_o} !== {1'b1, 8'hAF, 1'b0, 2'b01}) begin
            errors++;
            $display("FAIL single_start got=start%b data%h dc%b grant%b want=start1 dataaf dc0 grant01",
                     spi_start_o, spi_data_o, dc_o, grant_o);
        end
        tick(); #4; checks++;
        if ({spi_start_o, busy_o, grant_o, spi_data_o} !== {1'b0, 1'b1, 2'b01, 8'hAF}) begin
            errors++;
            $display("FAIL single_wait got=start%b busy%b grant%b data%h want=start0 busy1 grant01 dataaf",
                     spi_start_o, busy_o, grant_o, spi_data_o);
        end
        spi_done_i = 1;
        tick(); spi_done_i = 0;
        #4; checks++;
        if ({busy_o, grant_o, spi_data_o, dc_o} !== {1'b0, 2'b00, 8'hAF, 1'b0}) begin
            errors++;
            $display("FAIL single_done got=busy%b grant%b data%h dc%b want=busy0 grant00 dataaf dc0",
                     busy_o, grant_o, spi_data_o, dc_o);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] g; logic [7:0] d; logic dc;
        logic [1:0] exp_g;
        apply_reset();
        cmd_valid_i = 1; cmd_data_i = 8'h15; cmd_dc_i = 0;
        pix_valid_i = 1; pix_data_i = 8'h3C;
        for (int k = 0; k < 4; k++) begin
            run_xfer(0, g, d, dc);
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            checks++;
            if ({g, d, dc} !== {exp_g, (k % 2 == 0) ? 8'h15 : 8'h3C, (k % 2 == 0) ? 1'b0 : 1'b1}) begin
                errors++;
                $display("FAIL rr_xfer%0d got=grant%b data%h dc%b want=grant%b", k, g, d, dc, exp_g);
            end
        end
        cmd_valid_i = 0; pix_valid_i = 0;
    endtask

    task automatic test_lock();
        logic [1:0] g; logic [7:0] d; logic dc;
        logic [7:0] seq [3];
        seq[0] = 8'h75; seq[1] = 8'h00; seq[2] = 8'h3F;
        apply_reset();
        pix_valid_i = 1; pix_data_i = 8'hE7;
        cmd_valid_i = 1; cmd_lock_i = 1; cmd_dc_i = 0;
        for (int k = 0; k < 3; k++) begin
            cmd_data_i = seq[k];
            run_xfer(1, g, d, dc);
            checks++;
            if ({g, d, dc} !== {2'b01, seq[k], 1'b0}) begin
                errors++;
                $display("FAIL lock_xfer%0d got=grant%b data%h dc%b want=grant01 data%h dc0", k, g, d, dc, seq[k]);
            end
        end
        cmd_valid_i = 0; cmd_lock_i = 0;
        #4; checks++;
        if (pix_ready_o !== 1'b0) begin errors++; $display("FAIL lock_release_cycle got=%b want=0", pix_ready_o); end
        run_xfer(0, g, d, dc);
        checks++;
        if ({g, d, dc} !== {2'b10, 8'hE7, 1'b1}) begin
            errors++;
            $display("FAIL lock_pix_after got=grant%b data%h dc%b want=grant10 datae7 dc1", g, d, dc);
        end
        pix_valid_i = 0;
    endtask

    task automatic test_busy_start();
        int starts;
        apply_reset();
        spi_busy_i = 1;
        cmd_valid_i = 1; cmd_data_i = 8'h5A; cmd_dc_i = 1;
        tick(); cmd_valid_i = 0;
        starts = 0;
        for (int i = 0; i < 5; i++) begin
            #4; if (spi_start_o === 1'b1) starts++;
            tick();
        end
        checks++;
        if (starts != 0) begin errors++; $display("FAIL busy_hold_start got=%0d starts want=0", starts); end
        spi_busy_i = 0;
        #4; checks++;
        if ({spi_start_o, dc_o, spi_data_o} !== {1'b1, 1'b1, 8'h5A}) begin
            errors++;
            $display("FAIL busy_release got=start%b dc%b data%h want=start1 dc1 data5a", spi_start_o, dc_o, spi_data_o);
        end
        tick(); #4; checks++;
        if ({spi_start_o, busy_o} !== 2'b01) begin
            errors++;
            $display("FAIL busy_once got=start%b busy%b want=start0 busy1", spi_start_o, busy_o);
        end
        spi_done_i = 1; tick(); spi_done_i = 0;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        cmd_valid_i = 1; cmd_data_i = 8'hC3; cmd_dc_i = 1; cmd_lock_i = 1;
        tick(); cmd_valid_i = 0; cmd_lock_i = 0;
        tick(); tick();
        rstn_i = 0;
        #4; checks++;
        if ({spi_start_o, spi_data_o, dc_o, grant_o, busy_o} !== 13'h0) begin
            errors++;
            $display("FAIL rstmid_outputs got=start%b data%h dc%b grant%b busy%b want=all 0",
                     spi_start_o, spi_data_o, dc_o, grant_o, busy_o);
        end
        tick(); rstn_i = 1; spi_done_i = 1;
        #4; checks++;
        if ({spi_start_o, grant_o, busy_o} !== 4'h0) begin
            errors++;
            $display("FAIL rstmid_stray_done got=start%b grant%b busy%b want=0", spi_start_o, grant_o, busy_o);
        end
        tick(); spi_done_i = 0;
        cmd_valid_i = 1; cmd_data_i = 8'h11; cmd_dc_i = 0; pix_valid_i = 1; pix_data_i = 8'h22;
        #4; checks++;
        if ({cmd_ready_o, pix_ready_o} !== 2'b10) begin
            errors++;
            $display("FAIL rstmid_tie got=cmd%b pix%b want=cmd1 pix0", cmd_ready_o, pix_ready_o);
        end
        tick(); cmd_valid_i = 0; pix_valid_i = 0;
        tick(); spi_done_i = 1; tick(); spi_done_i = 0;
    endtask

`ifdef OLED_SPI_ARB_TIMEOUT_EN
    task automatic test_timeout();
        apply_reset();
        cmd_valid_i = 1; cmd_data_i = 8'h99; cmd_dc_i = 0;
        tick(); cmd_valid_i = 0;
        tick();
        for (int i = 0; i < 16; i++) begin
            #4; checks++;
            if (busy_o !== 1'b1 || timeout_o !== 1'b0) begin
                errors++;
                $display("FAIL timeout_early cycle%0d got=busy%b to%b want=busy1 to0", i, busy_o, timeout_o);
            end
            tick();
        end
        #4; checks++;
        if ({busy_o, timeout_o, grant_o} !== 4'b0100) begin
            errors++;
            $display("FAIL timeout_hit got=busy%b to%b grant%b want=busy0 to1 grant00", busy_o, timeout_o, grant_o);
        end
        tick(); tick(); #4; checks++;
        if (timeout_o !== 1'b1) begin errors++; $display("FAIL timeout_sticky got=%b want=1", timeout_o); end
    endtask
`else
    task automatic test_timeout();
        apply_reset();
        cmd_valid_i = 1; cmd_data_i = 8'h99; cmd_dc_i = 0;
        tick(); cmd_valid_i = 0;
        repeat (40) tick();
        #4; checks++;
        if ({busy_o, timeout_o, grant_o} !== 4'b1001) begin
            errors++;
            $display("FAIL no_watchdog got=busy%b to%b grant%b want=busy1 to0 grant01", busy_o, timeout_o, grant_o);
        end
        tick(); spi_done_i = 1; tick(); spi_done_i = 0;
    endtask
`endif

    // Transaction-level model: tracks who owns the shared master and what was handed to it.
    task automatic test_random();
        bit m_last_pix, m_lock, m_tx, m_started;
        logic [7:0] m_data; logic m_dc; logic [1:0] m_grant;
        bit c_pend, c_dc, c_lock, p_pend;
        logic [7:0] c_data, p_data;
        int sm_cnt, sm_pre;
        bit exp_cr, exp_pr, exp_start;
        apply_reset();
        m_last_pix = 1; m_lock = 0; m_tx = 0; m_started = 0;
        m_data = 0; m_dc = 0; m_grant = 0;
        c_pend = 0; p_pend = 0; c_data = 0; p_data = 0; c_dc = 0; c_lock = 0;
        sm_cnt = 0; sm_pre = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            if (!c_pend && $urandom_range(0, 2) == 0) begin
                c_pend = 1; c_data = 8'($urandom); c_dc = 1'($urandom); c_lock = ($urandom_range(0, 2) == 0);
            end
            if (!p_pend && $urandom_range(0, 1) == 0) begin
                p_pend = 1; p_data = 8'($urandom);
            end
            cmd_valid_i = c_pend; cmd_data_i = c_data; cmd_dc_i = c_dc;
            cmd_lock_i = c_pend ? c_lock : ($urandom_range(0, 3) == 0);
            pix_valid_i = p_pend; pix_data_i = p_data;
            spi_busy_i = (sm_cnt > 0) || (sm_pre > 0);
            spi_done_i = (sm_cnt == 1) || (!(m_tx && m_started) && $urandom_range(0, 7) == 0);
            #4;
            exp_cr = 0; exp_pr = 0;
            if (!m_tx) begin
                if (m_lock) exp_cr = c_pend;
                else if (c_pend && p_pend) begin exp_cr = m_last_pix; exp_pr = !m_last_pix; end
                else begin exp_cr = c_pend; exp_pr = p_pend; end
            end
            exp_start = m_tx && !m_started && !spi_busy_i;
            checks++;
            if ({cmd_ready_o, pix_ready_o, spi_start_o, busy_o} !== {exp_cr, exp_pr, exp_start, m_tx}) begin
                errors++;
                $display("FAIL rand_ctrl cyc%0d got=rdy%b%b start%b busy%b want=rdy%b%b start%b busy%b",
                         cyc, cmd_ready_o, pix_ready_o, spi_start_o, busy_o, exp_cr, exp_pr, exp_start, m_tx);
            end
            checks++;
            if ({spi_data_o, dc_o, grant_o, timeout_o} !== {m_data, m_dc, m_grant, 1'b0}) begin
                errors++;
                $display("FAIL rand_data cyc%0d got=data%h dc%b grant%b to%b want=data%h dc%b grant%b to0",
                         cyc, spi_data_o, dc_o, grant_o, timeout_o, m_data, m_dc, m_grant);
            end
            if (sm_cnt > 0) sm_cnt--;
            if (sm_pre > 0) sm_pre--;
            if (!m_tx) begin
                if (exp_cr) begin
                    m_tx = 1; m_started = 0; m_data = c_data; m_dc = c_dc; m_grant = 2'b01;
                    m_last_pix = 0; m_lock = c_lock; c_pend = 0;
                    if ($urandom_range(0, 2) == 0) sm_pre = $urandom_range(1, 3);
                end else if (exp_pr) begin
                    m_tx = 1; m_started = 0; m_data = p_data; m_dc = 1; m_grant = 2'b10;
                    m_last_pix = 1; m_lock = 0; p_pend = 0;
                    if ($urandom_range(0, 2) == 0) sm_pre = $urandom_range(1, 3);
                end else if (!c_pend && !cmd_lock_i) begin
                    m_lock = 0;
                end
            end else if (!m_started) begin
                if (!spi_busy_i) begin m_started = 1; sm_cnt = $urandom_range(1, 4); end
            end else if (spi_done_i) begin
                m_tx = 0; m_grant = 2'b00;
            end
        end
        cmd_valid_i = 0; pix_valid_i = 0; cmd_lock_i = 0; spi_busy_i = 0; spi_done_i = 0;
    endtask

    initial begin
        test_reset();
        test_single_cmd();
        test_round_robin();
        test_lock();
        test_busy_start();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/oled_spi_arbiter.md
Name: oled_spi_arbiter

Overview:
- Shares one spi_master between two requesters: a command/init sequencer and a pixel stream source.
- Serialises byte transfers and drives the OLED D/C line per transfer: command bytes use the requester's DC, pixel bytes force DC=1.
- Round-robin arbitration, plus a lock that lets the command side issue multi-byte sequences without pixel interleave.
- Sits between oled_controller-style sources and spi_master; spi_master is unchanged.

Parameters:
- DATA_WIDTH, 8, width of every SPI byte/word path.
- TIMEOUT_CYC, 4096, watchdog limit in clk_i cycles (used only with the optional feature).

Ports:
- clk_i  input  1  system clock
- rstn_i  input  1  reset; asynchronous assert, active-low
- cmd_valid_i  input  1  command requester has a byte
- cmd_data_i  input  DATA_WIDTH  command byte
- cmd_dc_i  input  1  D/C value for this command byte
- cmd_lock_i  input  1  hold the resource for the command side after the current byte
- cmd_ready_o  output  1  command byte accepted when valid&ready
- pix_valid_i  input  1  pixel requester has a byte
- pix_data_i  input  DATA_WIDTH  pixel byte
- pix_ready_o  output  1  pixel byte accepted when valid&ready
- spi_start_o  output  1  one-cycle start pulse to spi_master
- spi_data_o  output  DATA_WIDTH  byte presented to spi_master
- spi_busy_i  input  1  spi_master busy
- spi_done_i  input  1  spi_master transfer complete pulse
- dc_o  output  1  OLED D/C pin
- grant_o  output  2  one-hot owner of the current transfer: [0]=cmd, [1]=pix; 0 when idle
- busy_o  output  1  a transfer is in flight (state != IDLE)
- timeout_o  output  1  sticky watchdog flag

Behaviour:
- Reset values: all outputs 0; state IDLE; last_owner=pix, so cmd wins the first tie; lock_r=0.
- Ready outputs are combinational: asserted only in IDLE, and only toward the selected winner. A byte is accepted on valid&ready.
- Winner selection in IDLE:
  - lock_r=1: cmd only. pix_ready_o stays 0 even if pix_valid_i=1.
  - Only one valid: that requester wins.
  - Both valid: the requester that is not last_owner wins.
- Accept cycle:
  - Register spi_data_o from the winner's data.
  - Register dc_o: cmd_dc_i for cmd, 1 for pix.
  - Set grant_o and last_owner; capture lock_r = cmd_lock_i for a cmd accept, 0 for a pix accept.
  - Go to START.
- START:
  - Assert spi_start_o for exactly one cycle, only when spi_busy_i=0; otherwise stay in START with spi_start_o low.
  - Then go to WAIT_DONE.
  - Latency: accept at cycle N gives spi_start_o at N+1 if the master is idle.
- WAIT_DONE:
  - On spi_done_i go to IDLE and clear grant_o.
  - The next accept is possible the following cycle, so there is a minimum one idle cycle between transfers.
- spi_done_i is ignored in IDLE and START.
- dc_o and spi_data_o hold their values until the next accept; they never glitch mid-transfer.
- lock_r clears when cmd_lock_i=0 is sampled in IDLE with cmd_valid_i=0, or at the next cmd accept with cmd_lock_i=0.
- Reset mid-transfer: state and outputs return to reset values immediately; no spi_start_o is reissued.

Optional Feature:
- Macro: OLED_SPI_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in START and WAIT_DONE and clears on every state change.
  - Reaching TIMEOUT_CYC forces IDLE, clears grant_o and lock_r, and sets timeout_o.
  - timeout_o stays set until reset.
- Undefined: no counter; timeout_o is tied 0; the block waits forever for spi_done_i.

Decomposition:
- Package oled_spi_pkg holds:
  - FSM state encoding: IDLE, START, WAIT_DONE.
  - Owner encoding: OWN_CMD=0, OWN_PIX=1.
  - DC_CMD=0 and DC_DATA=1 constants.
- One sub-module, oled_spi_rr_sel: combinational two-way round-robin/lock winner select.
- The FSM and datapath registers stay in the top module.

Test Plan:
- Single cmd byte: cmd_valid_i=1, cmd_data_i=8'hAF, cmd_dc_i=0 -> cmd_ready_o high one cycle; spi_start_o the next cycle; spi_data_o=8'hAF, dc_o=0, grant_o=2'b01 until spi_done_i.
- Both valid continuously: cmd 8'h15 and pix 8'h3C, 4 transfers -> grant order cmd, pix, cmd, pix; dc_o pattern 0,1,0,1.
- Lock: cmd_lock_i=1 over 3 cmd bytes (8'h75, 8'h00, 8'h3F) with pix_valid_i=1 throughout -> all 3 cmd bytes go before any pix; pix_ready_o=0 until the lock releases.
- Master busy at start: spi_busy_i held 1 for 5 cycles after accept -> spi_start_o fires in the first cycle spi_busy_i=0, exactly once.
- Reset in WAIT_DONE: rstn_i low for 1 cycle -> all outputs 0 and busy_o=0; a later stray spi_done_i has no effect; the next tie is won by cmd.
- With OLED_SPI_ARB_TIMEOUT_EN and TIMEOUT_CYC=16, spi_done_i never returned -> after 16 cycles in WAIT_DONE: IDLE, timeout_o=1, grant_o=0.
